// File: rtl/spi_target_if.sv
// Bundles the SPI pins, the RX/TX byte ports and the status flags of spi_target.
//
// Handshake rules for both byte ports: a transfer happens on a clk edge where
// valid and ready are both high. A source that raises valid keeps data stable
// until that edge. valid does not depend on ready. ready may be high while
// valid is low.
interface spi_target_if;
    logic       sck;
    logic       mosi;
    logic       nss;
    logic       miso;
    logic       miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ovr_clr;
    logic       overrun;
    logic       busy;

    // Device side.
    modport slave (
        input  sck, mosi, nss, rx_ready, tx_data, tx_valid, ovr_clr,
        output miso, miso_oe, rx_data, rx_valid, tx_ready, overrun, busy
    );

    // SPI master and system side.
    modport master (
        output sck, mosi, nss, rx_ready, tx_data, tx_valid, ovr_clr,
        input  miso, miso_oe, rx_data, rx_valid, tx_ready, overrun, busy
    );
endinterface

// File: rtl/spi_target.sv
// spi_target: SPI mode 0 responder, MSB first. The SPI pins are oversampled on clk.
// Received bytes leave on a valid/ready port. Bytes to send arrive on a second
// valid/ready port and wait in a one-entry holding register.
// Optional feature: define SPI_TARGET_RXFIFO_EN to replace the single RX holding
// register with a 2**RX_DEPTH_LOG2-entry first-word-fall-through FIFO.
module spi_target #(
    parameter int         SYNC_STAGES   = 2,
    parameter logic [7:0] IDLE_BYTE     = 8'hFF,
    parameter int         RX_DEPTH_LOG2 = 2
) (
    input  logic         clk,
    input  logic         rst,
    spi_target_if.slave  bus,
    output logic         dbg_state
);
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, nss_sync;
    logic sck_prev, nss_prev;
    logic sck_s, mosi_s, nss_s;
    logic sck_rise, sck_fall, nss_rise, nss_fall;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift, tx_shift, hold_data;
    logic       hold_full, byte_done;
    logic       miso, miso_oe, busy;
    logic       load, rx_pop, overrun_q;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign nss_s  = nss_sync[SYNC_STAGES-1];

    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign nss_rise = nss_s & ~nss_prev;
    assign nss_fall = ~nss_s & nss_prev;

    // The nss chain resets to "selected". If nss is held low through reset, no
    // falling edge is seen afterwards, so a transfer only starts after nss has
    // been released and lowered again.
    // Synchronize the SPI pins and keep the previous samples for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            nss_sync  <= '0;
            sck_prev  <= 1'b0;
            nss_prev  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            nss_sync  <= {nss_sync[SYNC_STAGES-2:0], bus.nss};
            sck_prev  <= sck_s;
            nss_prev  <= nss_s;
        end
    end

    // A load happens only when holding is empty. A reload empties holding only
    // when it is full, so a load and an emptying reload never occur in the same clk.
    assign load = bus.tx_valid && !hold_full;

    // Control FSM plus the shift registers and the TX holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            rx_shift  <= 8'h00;
            tx_shift  <= IDLE_BYTE;
            hold_data <= 8'h00;
            hold_full <= 1'b0;
            byte_done <= 1'b0;
            miso      <= 1'b1;
            miso_oe   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (load) begin
                hold_data <= bus.tx_data;
                hold_full <= 1'b1;
            end
            case (state)
                IDLE: begin
                    miso     <= 1'b1;
                    miso_oe  <= 1'b0;
                    busy     <= 1'b0;
                    bit_cnt  <= 3'd0;
                    rx_shift <= 8'h00;
                    if (nss_fall) begin
                        state    <= SHIFT;
                        miso_oe  <= 1'b1;
                        busy     <= 1'b1;
                        tx_shift <= hold_full ? hold_data : IDLE_BYTE;
                        if (hold_full) hold_full <= 1'b0;
                    end
                end
                SHIFT: begin
                    miso <= tx_shift[7];
                    if (nss_rise) begin
                        state   <= IDLE;
                        miso    <= 1'b1;
                        miso_oe <= 1'b0;
                        busy    <= 1'b0;
                        bit_cnt <= 3'd0;
                    end else if (sck_rise) begin
                        rx_shift <= {rx_shift[6:0], mosi_s};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) byte_done <= 1'b1;
                    end else if (sck_fall) begin
                        if (bit_cnt == 3'd0) begin
                            tx_shift <= hold_full ? hold_data : IDLE_BYTE;
                            if (hold_full) hold_full <= 1'b0;
                        end else begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rx_pop = bus.rx_valid && bus.rx_ready;

`ifdef SPI_TARGET_RXFIFO_EN
    localparam int DEPTH = 1 << RX_DEPTH_LOG2;

    logic [7:0]             fifo_mem [DEPTH];
    logic [RX_DEPTH_LOG2:0] wr_ptr, rd_ptr;
    logic                   fifo_empty, fifo_full, push_ok;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[RX_DEPTH_LOG2] != rd_ptr[RX_DEPTH_LOG2]) &&
                        (wr_ptr[RX_DEPTH_LOG2-1:0] == rd_ptr[RX_DEPTH_LOG2-1:0]);
    // A pop in the same clk frees a slot, so a full FIFO still accepts the byte.
    assign push_ok    = byte_done && (!fifo_full || rx_pop);

    // Write a completed byte into the FIFO storage.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr[RX_DEPTH_LOG2-1:0]] <= rx_shift;
    end

    // Update the FIFO pointers and the sticky overrun flag. A set beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + {{RX_DEPTH_LOG2{1'b0}}, 1'b1};
            if (rx_pop)  rd_ptr <= rd_ptr + {{RX_DEPTH_LOG2{1'b0}}, 1'b1};
            if (bus.ovr_clr) overrun_q <= 1'b0;
            if (byte_done && !push_ok) overrun_q <= 1'b1;
        end
    end

    assign bus.rx_valid = !fifo_empty;
    assign bus.rx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr[RX_DEPTH_LOG2-1:0]];
`else
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       unused_cfg;

    // RX_DEPTH_LOG2 has no effect with a single holding register.
    assign unused_cfg = (RX_DEPTH_LOG2 > 0);

    // Single RX holding register with the sticky overrun flag. A set beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (byte_done && (!rx_valid_q || rx_pop)) begin
                rx_data_q  <= rx_shift;
                rx_valid_q <= 1'b1;
            end else if (rx_pop) begin
                rx_valid_q <= 1'b0;
            end
            if (bus.ovr_clr) overrun_q <= 1'b0;
            if (byte_done && rx_valid_q && !rx_pop) overrun_q <= 1'b1;
        end
    end

    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;
`endif

    assign bus.miso     = miso;
    assign bus.miso_oe  = miso_oe;
    assign bus.busy     = busy;
    assign bus.tx_ready = !hold_full;
    assign bus.overrun  = overrun_q;
    assign dbg_state    = logic'(state);
endmodule

// File: tb/tb_spi_target.sv
// Testbench for spi_target. It drives mode 0 SPI traffic and checks the bytes
// the master reads back on miso. A monitor compares every RX handshake with a
// queue of expected bytes.
module tb_spi_target;
    localparam int HALF = 8;   // clk cycles per SCK half period

    logic clk;
    logic rst;
    logic dbg_state;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] exp_q[$];

    spi_target_if bus();

    spi_target #(
        .SYNC_STAGES(2),
        .IDLE_BYTE(8'hFF),
        .RX_DEPTH_LOG2(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .dbg_state(dbg_state)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion within 500000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    // RX monitor: every handshake pops one expected byte.
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (!rst && bus.rx_valid && bus.rx_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rx_unexpected: got 0x%0h required no byte", bus.rx_data);
            end else begin
                exp_b = exp_q.pop_front();
                check("rx_data", {24'h0, bus.rx_data}, {24'h0, exp_b});
            end
        end
    end

    // Advance n clocks. Inputs then change 1 ns after the edge.
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tx_load(input logic [7:0] d);
        bit done;
        done = 1'b0;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (bus.tx_ready) done = 1'b1;
            wait_clks(1);
        end
        bus.tx_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL tx_load_timeout: got tx_ready=0 required 1 within 50 clks");
        end
    endtask

    task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = mo[7-i];
            wait_clks(HALF);
            bus.sck = 1'b1;
            mi = {mi[6:0], bus.miso};
            wait_clks(HALF);
            bus.sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] mo, input logic [7:0] exp_mi, input string name);
        logic [7:0] mi;
        spi_bits(mo, 8, mi);
        check(name, {24'h0, mi}, {24'h0, exp_mi});
    endtask

    task automatic select();
        bus.nss = 1'b0;
        wait_clks(HALF + 2);
    endtask

    task automatic deselect();
        wait_clks(HALF);
        bus.nss = 1'b1;
        wait_clks(HALF);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_miso"},     {31'h0, bus.miso},     32'h1);
        check({tag, "_miso_oe"},  {31'h0, bus.miso_oe},  32'h0);
        check({tag, "_rx_data"},  {24'h0, bus.rx_data},  32'h0);
        check({tag, "_rx_valid"}, {31'h0, bus.rx_valid}, 32'h0);
        check({tag, "_tx_ready"}, {31'h0, bus.tx_ready}, 32'h1);
        check({tag, "_overrun"},  {31'h0, bus.overrun},  32'h0);
        check({tag, "_busy"},     {31'h0, bus.busy},     32'h0);
        check({tag, "_state"},    {31'h0, dbg_state},    32'h0);
    endtask

    // main stimulus
    initial begin
        logic [7:0] junk;
        rst          = 1'b1;
        bus.sck      = 1'b0;
        bus.mosi     = 1'b0;
        bus.nss      = 1'b1;
        bus.rx_ready = 1'b1;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        bus.ovr_clr  = 1'b0;
        wait_clks(5);
        rst = 1'b0;
        check_reset_values("reset");
        wait_clks(5);

        // T1: TX 0x3C queued, master sends 0xA5
        tx_load(8'h3C);
        check("t1_tx_ready_full", {31'h0, bus.tx_ready}, 32'h0);
        select();
        check("t1_busy",          {31'h0, bus.busy},     32'h1);
        check("t1_miso_oe",       {31'h0, bus.miso_oe},  32'h1);
        check("t1_tx_ready_free", {31'h0, bus.tx_ready}, 32'h1);
        check("t1_state",         {31'h0, dbg_state},    32'h1);
        check("t1_first_bit",     {31'h0, bus.miso},     32'h0);
        exp_q.push_back(8'hA5);
        spi_byte(8'hA5, 8'h3C, "t1_miso_byte");
        deselect();
        check("t1_busy_off", {31'h0, bus.busy},    32'h0);
        check("t1_oe_off",   {31'h0, bus.miso_oe}, 32'h0);
        check("t1_miso_idle", {31'h0, bus.miso},   32'h1);

        // T2: nothing queued, master sends 0x00 and reads IDLE_BYTE
        select();
        exp_q.push_back(8'h00);
        spi_byte(8'h00, 8'hFF, "t2_miso_idle_byte");
        deselect();

        // T3: consumer stalled, overrun
        bus.rx_ready = 1'b0;
        select();
`ifdef SPI_TARGET_RXFIFO_EN
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        spi_byte(8'h11, 8'hFF, "t3_miso_0");
        spi_byte(8'h22, 8'hFF, "t3_miso_1");
        spi_byte(8'h33, 8'hFF, "t3_miso_2");
        spi_byte(8'h44, 8'hFF, "t3_miso_3");
        spi_byte(8'h55, 8'hFF, "t3_miso_4");
`else
        exp_q.push_back(8'h11);
        spi_byte(8'h11, 8'hFF, "t3_miso_0");
        spi_byte(8'h22, 8'hFF, "t3_miso_1");
`endif
        deselect();
        check("t3_overrun_set", {31'h0, bus.overrun},  32'h1);
        check("t3_rx_head",     {24'h0, bus.rx_data},  32'h11);
        check("t3_rx_valid",    {31'h0, bus.rx_valid}, 32'h1);
        bus.rx_ready = 1'b1;
        wait_clks(8);
        bus.ovr_clr = 1'b1;
        wait_clks(1);
        bus.ovr_clr = 1'b0;
        check("t3_overrun_clr", {31'h0, bus.overrun}, 32'h0);
        check("t3_rx_empty",    {31'h0, bus.rx_valid}, 32'h0);

        // T4: nss raised after 5 bits, then a clean 0x5A
        select();
        spi_bits(8'hC3, 5, junk);
        deselect();
        check("t4_no_partial", {31'h0, bus.rx_valid}, 32'h0);
        select();
        exp_q.push_back(8'h5A);
        spi_byte(8'h5A, 8'hFF, "t4_miso");
        deselect();

        // T5: reset mid-byte, clocking continues with nss still low
        tx_load(8'hE7);
        select();
        spi_bits(8'hF0, 3, junk);
        rst = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(1);
        check_reset_values("t5");
        spi_bits(8'hFF, 5, junk);
        check("t5_no_rx_after_reset", {31'h0, bus.rx_valid}, 32'h0);
        check("t5_still_idle",        {31'h0, bus.busy},     32'h0);
        deselect();
        tx_load(8'h69);
        select();
        exp_q.push_back(8'h96);
        spi_byte(8'h96, 8'h69, "t5_miso");
        deselect();

        // T6: back-to-back bytes, second TX byte loaded during byte 1
        tx_load(8'h80);
        select();
        tx_load(8'h81);
        check("t6_hold_full", {31'h0, bus.tx_ready}, 32'h0);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        spi_byte(8'h01, 8'h80, "t6_miso_0");
        spi_byte(8'h02, 8'h81, "t6_miso_1");
        deselect();
        check("t6_no_overrun", {31'h0, bus.overrun}, 32'h0);

        // drain
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) wait_clks(1);
        check("rx_queue_drained", exp_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
